// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: DIFF = A - B - Bin, one 4-bit slice per clock, LSB nibble first.
// A single registered borrow carries between slices; valid/ready handshake on both sides.
module nibble_serial_sub #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   A,
   input  logic [4*NIBBLES-1:0]   B,
   input  logic                   Bin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   DIFF,
   output logic                   Bout,
   output logic                   OVF
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    diff_q, diff_d;
   logic            borrow_q, borrow_d;
   logic            bout_q, bout_d;
   logic            ovf_q, ovf_d;
   logic            out_valid_q, out_valid_d;

   logic [3:0]      a_nib, b_nib;
   logic [4:0]      sub;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      bout_d      = bout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      a_nib = a_q[4*cnt_q +: 4];
      b_nib = b_q[4*cnt_q +: 4];
      // Bit 4 of the 5-bit difference is the borrow out of this slice.
      sub   = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = A;
               b_d      = B;
               borrow_d = Bin;
               cnt_d    = '0;
               diff_d   = '0;
               bout_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            diff_d[4*cnt_q +: 4] = sub[3:0];
            borrow_d             = sub[4];
            cnt_d                = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               cnt_d       = '0;
               bout_d      = sub[4];
               ovf_d       = (a_q[W-1] ^ b_q[W-1]) & (sub[3] ^ a_q[W-1]);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         bout_q      <= bout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign DIFF      = diff_q;
   assign Bout      = bout_q;
   assign OVF       = ovf_q;

endmodule
